// File: rtl/scope_pkg.sv
// scope_pkg: shared definitions for the oscilloscope acquisition stage.
// Contents: FSM state encoding, record geometry, slope/mode codes and the
// decimation terminal-count helper.
package scope_pkg;

  localparam int DEPTH        = 640;   // samples per record, one per display column
  localparam int DW           = 8;     // sample width
  localparam int ADDR_W       = 10;    // column address width
  localparam int AUTO_TIMEOUT = 4096;  // ARMED strobes before auto mode forces a capture
  localparam int TO_W         = 12;    // timeout counter width (holds AUTO_TIMEOUT-1)
  localparam int DEC_W        = 6;     // decimation counter width (holds 63)

  typedef enum logic [1:0] {
    ARMED     = 2'd0,
    CAPTURE   = 2'd1,
    WAIT_SWAP = 2'd2
  } state_t;

  localparam logic SLOPE_RISE  = 1'b0;
  localparam logic SLOPE_FALL  = 1'b1;
  localparam logic MODE_NORMAL = 1'b0;
  localparam logic MODE_AUTO   = 1'b1;

  // Terminal count of the decimation counter: 4^tpd - 1.
  function automatic logic [DEC_W-1:0] dec_max(input logic [1:0] tpd);
    logic [DEC_W-1:0] v;
    case (tpd)
      2'd0:    v = 6'd0;
      2'd1:    v = 6'd3;
      2'd2:    v = 6'd15;
      default: v = 6'd63;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/scope_bank_ram.sv
// scope_bank_ram: one record bank, DEPTH x DW, one write port and one
// registered read port (maps onto a block RAM).
// Ports:
//   clk      system clock
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address (must be < DEPTH)
//   o_rdata  read data, one cycle after i_raddr
module scope_bank_ram
  import scope_pkg::*;
(
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DW-1:0]     i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DW-1:0]     o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  // No reset on the memory or its output register so the array stays a
  // plain block RAM; the top gates the read data instead.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/scope_capture.sv
// scope_capture: trigger detection and decimated record capture into a
// ping-pong buffer feeding the display renderer.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   sample_in/valid   sample stream from the channel mux
//   level, slope      trigger threshold ({level,2'b00}) and edge direction
//   mode              0 normal, 1 auto (timeout forces a capture)
//   time_per_div      decimation: keep 1 of 4^time_per_div samples
//   frame_done        end-of-frame pulse; bank swaps only here
//   rd_addr/rd_data   display read port into the front bank, 1-cycle latency
//   buffer_valid      front bank holds a completed record (sticky)
//   triggered         front record came from a real trigger
//   state_o           FSM state for debug
module scope_capture
  import scope_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     sample_in,
  input  logic              sample_valid,
  input  logic [5:0]        level,
  input  logic              slope,
  input  logic              mode,
  input  logic [1:0]        time_per_div,
  input  logic              frame_done,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DW-1:0]     rd_data,
  output logic              buffer_valid,
  output logic              triggered,
  output logic [1:0]        state_o
);

  state_t            r_state, w_state_next;
  logic [DW-1:0]     r_prev;
  logic [TO_W-1:0]   r_to_cnt;
  logic [DEC_W-1:0]  r_dec_cnt;
  logic [ADDR_W-1:0] r_waddr;
  logic [1:0]        r_tpd;
  logic              r_trig_flag, r_bank_sel, r_buffer_valid, r_triggered;
  logic              r_rd_ok, r_rd_bank;

  logic [DW-1:0]     w_thr;
  logic              w_rise, w_fall, w_trig, w_auto;
  logic              w_start, w_cap_wr, w_swap, w_we;
  logic [ADDR_W-1:0] w_waddr, w_rd_addr;
  logic [DW-1:0]     w_bank_q [2];

  assign w_thr  = {level, 2'b00};
  assign w_rise = (r_prev < w_thr) && (sample_in >= w_thr);
  assign w_fall = (r_prev >= w_thr) && (sample_in < w_thr);
  assign w_trig = sample_valid && ((slope == SLOPE_FALL) ? w_fall : w_rise);
  // The counter saturates at AUTO_TIMEOUT-1, so once expired in normal mode a
  // later switch to auto forces a capture on the next strobe.
  assign w_auto = sample_valid && (mode == MODE_AUTO) &&
                  (r_to_cnt == TO_W'(AUTO_TIMEOUT - 1));

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_cap_wr     = 1'b0;
    w_swap       = 1'b0;
    w_we         = 1'b0;
    w_waddr      = r_waddr;
    case (r_state)
      ARMED: begin
        // The trigger sample itself is the first column of the record.
        if (w_trig || w_auto) begin
          w_start      = 1'b1;
          w_we         = 1'b1;
          w_waddr      = '0;
          w_state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (sample_valid && (r_dec_cnt == dec_max(r_tpd))) begin
          w_cap_wr = 1'b1;
          w_we     = 1'b1;
          if (r_waddr == ADDR_W'(DEPTH - 1)) w_state_next = WAIT_SWAP;
        end
      end
      WAIT_SWAP: begin
        if (frame_done) begin
          w_swap       = 1'b1;
          w_state_next = ARMED;
        end
      end
      default: w_state_next = ARMED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ARMED;
      r_prev         <= '0;
      r_to_cnt       <= '0;
      r_dec_cnt      <= '0;
      r_waddr        <= '0;
      r_tpd          <= '0;
      r_trig_flag    <= 1'b0;
      r_bank_sel     <= 1'b0;
      r_buffer_valid <= 1'b0;
      r_triggered    <= 1'b0;
      r_rd_ok        <= 1'b0;
      r_rd_bank      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (sample_valid) r_prev <= sample_in;

      if (w_swap || w_start)
        r_to_cnt <= '0;
      else if ((r_state == ARMED) && sample_valid && (r_to_cnt != TO_W'(AUTO_TIMEOUT - 1)))
        r_to_cnt <= r_to_cnt + TO_W'(1);

      if (w_start) begin
        r_dec_cnt   <= '0;
        r_waddr     <= ADDR_W'(1);
        r_trig_flag <= w_trig;       // real trigger wins over a coincident timeout
        r_tpd       <= time_per_div;  // decimation frozen for the whole record
      end else if ((r_state == CAPTURE) && sample_valid) begin
        if (w_cap_wr) begin
          r_dec_cnt <= '0;
          r_waddr   <= r_waddr + ADDR_W'(1);
        end else begin
          r_dec_cnt <= r_dec_cnt + DEC_W'(1);
        end
      end

      if (w_swap) begin
        r_bank_sel     <= ~r_bank_sel;
        r_triggered    <= r_trig_flag;
        r_buffer_valid <= 1'b1;
      end

      // Bank select and range are captured with the address so the output
      // mux lines up with the RAM's registered data.
      r_rd_ok   <= (rd_addr < ADDR_W'(DEPTH));
      r_rd_bank <= r_bank_sel;
    end
  end

  assign w_rd_addr = (rd_addr < ADDR_W'(DEPTH)) ? rd_addr : '0;

  // Bank gi is written only while it is the back bank.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    localparam logic BANK_ID = 1'(gi);
    scope_bank_ram u_ram (
      .clk     (clk),
      .i_we    (w_we && (r_bank_sel != BANK_ID)),
      .i_waddr (w_waddr),
      .i_wdata (sample_in),
      .i_raddr (w_rd_addr),
      .o_rdata (w_bank_q[gi])
    );
  end

  // r_rd_ok clears asynchronously, forcing rd_data to 0 during reset.
  assign rd_data      = r_rd_ok ? w_bank_q[r_rd_bank] : '0;
  assign buffer_valid = r_buffer_valid;
  assign triggered    = r_triggered;
  assign state_o      = r_state;

endmodule

// File: tb/tb_scope_capture.sv
// tb_scope_capture: randomized bench for scope_capture with a record-level
// reference model and a read-data scoreboard.
module tb_scope_capture;

  localparam int NCOL = 640;

  typedef struct {
    int s;
    int lvl;
    int slope;
    int mode;
    int tpd;
  } smp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sample_in = '0;
  logic       sample_valid = 1'b0;
  logic [5:0] level = '0;
  logic       slope = 1'b0;
  logic       mode = 1'b0;
  logic [1:0] time_per_div = '0;
  logic       frame_done = 1'b0;
  logic [9:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       buffer_valid, triggered;
  logic [1:0] state_o;

  smp_t stream[$];
  int   exp_rec[NCOL];
  int   exp_flag;
  int   exp_end;
  int   exp_q[$];
  int   addr_q[$];
  int   total = 0;
  int   bad = 0;
  int   ramp_v = 0;
  logic rd_issue = 1'b0;
  logic rd_issue_d = 1'b0;

  scope_capture dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .level        (level),
    .slope        (slope),
    .mode         (mode),
    .time_per_div (time_per_div),
    .frame_done   (frame_done),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .buffer_valid (buffer_valid),
    .triggered    (triggered),
    .state_o      (state_o)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Scoreboard monitor: a read issued on one cycle is answered on the next.
  always @(posedge clk) rd_issue_d <= rd_issue;

  always @(negedge clk) begin
    if (rd_issue_d) begin
      if (exp_q.size() == 0) begin
        chk("rd_underflow", 1, 0);
      end else begin
        int e;
        int a;
        e = exp_q.pop_front();
        a = addr_q.pop_front();
        chk($sformatf("rd[%0d]", a), int'(rd_data), e);
      end
    end
  end

  // Reference: scan the samples seen since arming for the first trigger or
  // timeout, then pick every 4^tpd-th sample from there.
  function automatic void model(input int arm_start);
    int t;
    int step;
    t = -1;
    exp_flag = 0;
    for (int i = arm_start; i < stream.size(); i++) begin
      int  prev;
      int  thr;
      bit  trg;
      prev = (i == 0) ? 0 : stream[i-1].s;
      thr  = stream[i].lvl * 4;
      if (stream[i].slope == 0) trg = (prev < thr) && (stream[i].s >= thr);
      else                      trg = (prev >= thr) && (stream[i].s < thr);
      if (trg || (stream[i].mode == 1 && (i - arm_start) >= 4095)) begin
        t = i;
        exp_flag = trg ? 1 : 0;
        break;
      end
    end
    if (t < 0) begin
      exp_end = -1;
      for (int k = 0; k < NCOL; k++) exp_rec[k] = -1;
      return;
    end
    step = 1 << (2 * stream[t].tpd);
    for (int k = 0; k < NCOL; k++) begin
      int idx;
      idx = t + k * step;
      exp_rec[k] = (idx < stream.size()) ? stream[idx].s : -1;
    end
    exp_end = t + (NCOL - 1) * step;
  endfunction

  task automatic drive_sample(input int kind);
    sample_valid = ($urandom_range(3) != 0);
    if (sample_valid) begin
      int v;
      v = (kind == 1) ? 10 : (ramp_v % 256);
      ramp_v++;
      sample_in = 8'(v);
      stream.push_back('{v, int'(level), int'(slope), int'(mode), int'(time_per_div)});
    end
  endtask

  task automatic send_n(input int kind, input int n);
    int sent;
    sent = 0;
    while (sent < n) begin
      @(negedge clk);
      drive_sample(kind);
      if (sample_valid) sent++;
    end
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic send_until_wait(input int kind, input bit inject_fd);
    int ok;
    int cap_cycles;
    ok = 0;
    cap_cycles = 0;
    for (int n = 0; n < 20000; n++) begin
      @(negedge clk);
      frame_done = 1'b0;
      if (state_o == 2'd2) begin
        ok = 1;
        break;
      end
      if (state_o == 2'd1) cap_cycles++;
      if (inject_fd && cap_cycles == 30) frame_done = 1'b1;
      drive_sample(kind);
    end
    sample_valid = 1'b0;
    frame_done   = 1'b0;
    chk("reach_wait_swap", ok, 1);
  endtask

  task automatic do_swap(input int arm_start, input int bv_before);
    model(arm_start);
    chk("capture_end_index", exp_end, stream.size() - 1);
    repeat (3) @(negedge clk);
    chk("hold_wait_swap", int'(state_o), 2);
    chk("bv_before_swap", int'(buffer_valid), bv_before);
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
    chk("state_after_swap", int'(state_o), 0);
    chk("bv_after_swap", int'(buffer_valid), 1);
    chk("triggered", int'(triggered), exp_flag);
  endtask

  task automatic issue_rd(input int a);
    @(negedge clk);
    rd_addr  = 10'(a);
    rd_issue = 1'b1;
    exp_q.push_back((a < NCOL) ? exp_rec[a] : 0);
    addr_q.push_back(a);
  endtask

  task automatic do_reads();
    issue_rd(0);
    issue_rd(5);
    issue_rd(639);
    issue_rd(700);
    issue_rd(1023);
    for (int i = 0; i < 20; i++) issue_rd($urandom_range(639));
    for (int i = 0; i < 3; i++) issue_rd($urandom_range(1023, 640));
    @(negedge clk);
    rd_issue = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int arm;
    int ok;

    // Reset state
    #35;
    chk("rst_state", int'(state_o), 0);
    chk("rst_bv", int'(buffer_valid), 0);
    chk("rst_trig", int'(triggered), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    @(negedge clk);
    rst = 1'b0;
    arm = 0;

    // Normal mode, constant input: no capture ever starts
    level = 6'd32; slope = 1'b0; mode = 1'b0; time_per_div = 2'd0;
    send_n(1, 10000);
    chk("normal_const_state", int'(state_o), 0);
    chk("normal_const_bv", int'(buffer_valid), 0);

    // Rising ramp, frame_done pulsed mid-capture must be ignored
    ramp_v = 0;
    send_until_wait(0, 1'b1);
    do_swap(arm, 0);
    arm = stream.size();
    do_reads();

    // Falling ramp
    slope = 1'b1;
    ramp_v = 0;
    send_until_wait(0, 1'b0);
    do_swap(arm, 1);
    arm = stream.size();
    do_reads();

    // Rising ramp, 1 of 16
    slope = 1'b0; time_per_div = 2'd2;
    ramp_v = 0;
    send_until_wait(0, 1'b0);
    do_swap(arm, 1);
    arm = stream.size();
    do_reads();

    // Auto mode, constant input: forced capture
    mode = 1'b1; time_per_div = 2'd0;
    send_until_wait(1, 1'b0);
    do_swap(arm, 1);
    arm = stream.size();
    do_reads();

    // Reset in the middle of a capture
    mode = 1'b0;
    issue_rd(3);
    @(negedge clk);
    rd_issue = 1'b0;
    repeat (2) @(negedge clk);
    ramp_v = 0;
    ok = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (state_o == 2'd1) begin
        ok = 1;
        break;
      end
      drive_sample(0);
    end
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      drive_sample(0);
    end
    @(negedge clk);
    sample_valid = 1'b0;
    chk("entered_capture", ok, 1);
    chk("pre_rst_state", int'(state_o), 1);
    chk("pre_rst_rd_data", int'(rd_data), 10);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_state", int'(state_o), 0);
    chk("mid_rst_bv", int'(buffer_valid), 0);
    chk("mid_rst_trig", int'(triggered), 0);
    chk("mid_rst_rd_data", int'(rd_data), 0);
    @(negedge clk);
    rst = 1'b0;
    stream.delete();
    repeat (3) @(negedge clk);
    chk("post_rst_state", int'(state_o), 0);
    chk("post_rst_bv", int'(buffer_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
